// File: rtl/battleship_game_ctrl_if.sv
// Player-side bus of the Battleship game controller: debounced active-low
// buttons and ship count in, board/cursor/phase state out to the renderer.
interface battleship_game_ctrl_if #(
    parameter int TIMER_W = 29
);
    logic               move_up;
    logic               move_down;
    logic               move_left;
    logic               move_right;
    logic               confirm;
    logic [2:0]         amount_of_ships;
    logic [2:0]         cursor_i;
    logic [2:0]         cursor_j;
    logic [2:0]         phase;
    logic [2:0]         ships_placed;
    logic [24:0]        player_ships;
    logic [24:0]        player_shots;
    logic [24:0]        cpu_shots;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               err_pulse;
    logic [TIMER_W-1:0] turn_timer;

    modport master (
        output move_up, move_down, move_left, move_right, confirm, amount_of_ships,
        input  cursor_i, cursor_j, phase, ships_placed, player_ships, player_shots,
        input  cpu_shots, hit_pulse, miss_pulse, err_pulse, turn_timer
    );

    modport slave (
        input  move_up, move_down, move_left, move_right, confirm, amount_of_ships,
        output cursor_i, cursor_j, phase, ships_placed, player_ships, player_shots,
        output cpu_shots, hit_pulse, miss_pulse, err_pulse, turn_timer
    );
endinterface

// File: rtl/battleship_game_ctrl.sv
// Game-phase controller for a 5x5 Battleship board: cursor, player and CPU
// ship placement, turn alternation with a player turn timeout, win/lose.
// Every output is a flop; next-state logic lives in one always_comb.
module battleship_game_ctrl #(
    parameter int         TURN_CYCLES = 500_000_000,
    parameter int         TIMER_W     = 29,
    parameter logic [4:0] LFSR_SEED   = 5'b10101
) (
    input  logic                  clk,
    input  logic                  rst,
    battleship_game_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        PH_PLACE     = 3'd0,
        PH_CPU_PLACE = 3'd1,
        PH_PLAYER    = 3'd2,
        PH_CPU       = 3'd3,
        PH_WIN       = 3'd4,
        PH_LOSE      = 3'd5
    } phase_e;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [4:0]         SEED_EFF   = (LFSR_SEED == 5'b00000) ? 5'b00001 : LFSR_SEED;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TURN_CYCLES - 1);
    localparam logic [4:0]         NUM_CELLS  = 5'd25;

    function automatic logic [4:0] cell_idx(input logic [2:0] i, input logic [2:0] j);
        logic [4:0] ii;
        ii = {2'b00, i};
        return (ii << 2) + ii + {2'b00, j};
    endfunction

    // Lowest-numbered cell whose bit is still clear (target of an auto-fire).
    function automatic logic [4:0] lowest_clear(input logic [24:0] m);
        logic [4:0] r;
        r = 5'd0;
        for (int k = 24; k >= 0; k--) begin
            if (!m[k]) begin
                r = 5'(k);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] clamp_ships(input logic [2:0] a);
        if (a == 3'd0) begin
            return 3'd1;
        end else if (a > 3'd5) begin
            return 3'd5;
        end else begin
            return a;
        end
    endfunction

    phase_e             phase_q, phase_d;
    logic [2:0]         cursor_i_q, cursor_i_d;
    logic [2:0]         cursor_j_q, cursor_j_d;
    logic [4:0]         hist_q, hist_d;
    logic [2:0]         n_q;
    logic [2:0]         ships_placed_q, ships_placed_d;
    logic [24:0]        player_ships_q, player_ships_d;
    logic [24:0]        player_shots_q, player_shots_d;
    logic [24:0]        cpu_ships_q, cpu_ships_d;
    logic [24:0]        cpu_shots_q, cpu_shots_d;
    logic [2:0]         cpu_count_q, cpu_count_d;
    logic [2:0]         player_hits_q, player_hits_d;
    logic [2:0]         cpu_hits_q, cpu_hits_d;
    logic [4:0]         lfsr_q, lfsr_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               err_q, err_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    // Button order in the vectors: {up, down, left, right, confirm}.
    logic [4:0] btn_now_s;
    logic [4:0] press_s;
    logic [4:0] cur_idx_s;
    logic [4:0] cpu_cell_s;
    logic [4:0] lfsr_next_s;
    logic       fire_s;
    logic [4:0] fire_idx_s;

    assign btn_now_s   = {bus.move_up, bus.move_down, bus.move_left, bus.move_right, bus.confirm};
    assign press_s     = hist_q & ~btn_now_s;
    assign cur_idx_s   = cell_idx(cursor_i_q, cursor_j_q);
    assign cpu_cell_s  = lfsr_q - 5'd1;
    assign lfsr_next_s = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};

    // Next-state logic for cursor, game phase, board maps and pulses.
    always_comb begin
        phase_d        = phase_q;
        cursor_i_d     = cursor_i_q;
        cursor_j_d     = cursor_j_q;
        hist_d         = btn_now_s;
        ships_placed_d = ships_placed_q;
        player_ships_d = player_ships_q;
        player_shots_d = player_shots_q;
        cpu_ships_d    = cpu_ships_q;
        cpu_shots_d    = cpu_shots_q;
        cpu_count_d    = cpu_count_q;
        player_hits_d  = player_hits_q;
        cpu_hits_d     = cpu_hits_q;
        lfsr_d         = lfsr_q;
        hit_d          = 1'b0;
        miss_d         = 1'b0;
        err_d          = 1'b0;
        timer_d        = timer_q;
        fire_s         = 1'b0;
        fire_idx_s     = cur_idx_s;

        // Cursor only moves while the player is placing or aiming; only the
        // highest-priority press of the cycle is honoured.
        if ((phase_q == PH_PLACE) || (phase_q == PH_PLAYER)) begin
            if (press_s[4]) begin
                cursor_i_d = (cursor_i_q != 3'd0) ? cursor_i_q - 3'd1 : cursor_i_q;
            end else if (press_s[3]) begin
                cursor_i_d = (cursor_i_q != 3'd4) ? cursor_i_q + 3'd1 : cursor_i_q;
            end else if (press_s[2]) begin
                cursor_j_d = (cursor_j_q != 3'd0) ? cursor_j_q - 3'd1 : cursor_j_q;
            end else if (press_s[1]) begin
                cursor_j_d = (cursor_j_q != 3'd4) ? cursor_j_q + 3'd1 : cursor_j_q;
            end else begin
                cursor_i_d = cursor_i_q;
            end
        end else begin
            cursor_i_d = cursor_i_q;
        end

        case (phase_q)
            PH_PLACE: begin
                if (ships_placed_q == n_q) begin
                    phase_d = PH_CPU_PLACE;
                end else if (press_s[0]) begin
                    if (player_ships_q[cur_idx_s]) begin
                        err_d = 1'b1;
                    end else begin
                        player_ships_d[cur_idx_s] = 1'b1;
                        ships_placed_d            = ships_placed_q + 3'd1;
                    end
                end else begin
                    phase_d = PH_PLACE;
                end
            end
            PH_CPU_PLACE: begin
                lfsr_d = lfsr_next_s;
                if ((cpu_cell_s < NUM_CELLS) && !cpu_ships_q[cpu_cell_s]) begin
                    cpu_ships_d[cpu_cell_s] = 1'b1;
                    cpu_count_d             = cpu_count_q + 3'd1;
                    if ((cpu_count_q + 3'd1) == n_q) begin
                        phase_d = PH_PLAYER;
                        timer_d = TIMER_LOAD;
                    end else begin
                        phase_d = PH_CPU_PLACE;
                    end
                end else begin
                    phase_d = PH_CPU_PLACE;
                end
            end
            PH_PLAYER: begin
                // A valid manual shot beats the timeout; an invalid one during
                // timeout yields to the auto-fire so pulses never overlap.
                if (press_s[0] && !player_shots_q[cur_idx_s]) begin
                    fire_s     = 1'b1;
                    fire_idx_s = cur_idx_s;
                end else if (timer_q == {TIMER_W{1'b0}}) begin
                    fire_s     = 1'b1;
                    fire_idx_s = lowest_clear(player_shots_q);
                end else if (press_s[0]) begin
                    err_d = 1'b1;
                end else begin
                    fire_s = 1'b0;
                end

                if (fire_s) begin
                    player_shots_d[fire_idx_s] = 1'b1;
                    timer_d                    = {TIMER_W{1'b0}};
                    if (cpu_ships_q[fire_idx_s]) begin
                        hit_d         = 1'b1;
                        player_hits_d = player_hits_q + 3'd1;
                        phase_d       = ((player_hits_q + 3'd1) == n_q) ? PH_WIN : PH_CPU;
                    end else begin
                        miss_d  = 1'b1;
                        phase_d = PH_CPU;
                    end
                end else begin
                    timer_d = timer_q - {{(TIMER_W-1){1'b0}}, 1'b1};
                end
            end
            PH_CPU: begin
                lfsr_d = lfsr_next_s;
                if ((cpu_cell_s < NUM_CELLS) && !cpu_shots_q[cpu_cell_s]) begin
                    cpu_shots_d[cpu_cell_s] = 1'b1;
                    if (player_ships_q[cpu_cell_s]) begin
                        hit_d      = 1'b1;
                        cpu_hits_d = cpu_hits_q + 3'd1;
                        if ((cpu_hits_q + 3'd1) == n_q) begin
                            phase_d = PH_LOSE;
                        end else begin
                            phase_d = PH_PLAYER;
                            timer_d = TIMER_LOAD;
                        end
                    end else begin
                        miss_d  = 1'b1;
                        phase_d = PH_PLAYER;
                        timer_d = TIMER_LOAD;
                    end
                end else begin
                    phase_d = PH_CPU;
                end
            end
            PH_WIN, PH_LOSE: begin
                phase_d = phase_q;
            end
            default: begin
                phase_d = PH_PLACE;
            end
        endcase
    end

    // State register with synchronous reset; ship count captured while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q        <= PH_PLACE;
            cursor_i_q     <= 3'd0;
            cursor_j_q     <= 3'd0;
            hist_q         <= 5'b11111;
            n_q            <= clamp_ships(bus.amount_of_ships);
            ships_placed_q <= 3'd0;
            player_ships_q <= 25'd0;
            player_shots_q <= 25'd0;
            cpu_ships_q    <= 25'd0;
            cpu_shots_q    <= 25'd0;
            cpu_count_q    <= 3'd0;
            player_hits_q  <= 3'd0;
            cpu_hits_q     <= 3'd0;
            lfsr_q         <= SEED_EFF;
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
            err_q          <= 1'b0;
            timer_q        <= {TIMER_W{1'b0}};
        end else begin
            phase_q        <= phase_d;
            cursor_i_q     <= cursor_i_d;
            cursor_j_q     <= cursor_j_d;
            hist_q         <= hist_d;
            n_q            <= n_q;
            ships_placed_q <= ships_placed_d;
            player_ships_q <= player_ships_d;
            player_shots_q <= player_shots_d;
            cpu_ships_q    <= cpu_ships_d;
            cpu_shots_q    <= cpu_shots_d;
            cpu_count_q    <= cpu_count_d;
            player_hits_q  <= player_hits_d;
            cpu_hits_q     <= cpu_hits_d;
            lfsr_q         <= lfsr_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
            err_q          <= err_d;
            timer_q        <= timer_d;
        end
    end

    assign bus.cursor_i     = cursor_i_q;
    assign bus.cursor_j     = cursor_j_q;
    assign bus.phase        = phase_q;
    assign bus.ships_placed = ships_placed_q;
    assign bus.player_ships = player_ships_q;
    assign bus.player_shots = player_shots_q;
    assign bus.cpu_shots    = cpu_shots_q;
    assign bus.hit_pulse    = hit_q;
    assign bus.miss_pulse   = miss_q;
    assign bus.err_pulse    = err_q;
    assign bus.turn_timer   = timer_q;

endmodule
